// File: rtl/gray_pkg.sv
// Shared mode encodings and sizing helpers for the Gray/binary codec pipeline.
package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    localparam int unsigned MAX_WIDTH = 64;

    // Bits of the Gray->binary chain resolved per stage.
    function automatic int unsigned chunk_f(input int unsigned width, input int unsigned stages);
        return (width + stages - 1) / stages;
    endfunction

    // Hamming distance between two words, used by the optional step checker.
    function automatic int unsigned popcount_xor(input logic [MAX_WIDTH-1:0] a,
                                                 input logic [MAX_WIDTH-1:0] b);
        logic [MAX_WIDTH-1:0] x;
        int unsigned n;
        x = a ^ b;
        n = 0;
        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
            n = n + 32'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline register stage: resolves Gray bits HI..LO (or encodes binary in the
// first stage) and holds valid/mode/data/carry/err with a local load handshake.
module gray_codec_stage
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int          HI    = 3,
    parameter int          LO    = 0,
    parameter bit          FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic             up_mode,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_carry,
    input  logic             up_err,
    input  logic             down_ready,
    output logic             valid,
    output logic             mode,
    output logic [WIDTH-1:0] data,
    output logic             carry,
    output logic             err
);

    localparam bit               ACTIVE = (HI >= LO);
    localparam logic [WIDTH-1:0] ONES   = '1;
    localparam logic [WIDTH-1:0] MASK   = ACTIVE ? ((ONES >> (int'(WIDTH) - 1 - HI)) & (ONES << LO))
                                                 : '0;
    localparam logic [WIDTH-1:0] LO_BIT = WIDTH'(1) << LO;

    logic             load;
    logic [WIDTH-1:0] suffix;
    logic [WIDTH-1:0] nxt_data;
    logic             nxt_carry;

    assign load = !valid || down_ready;

    // Suffix XOR over the masked slice gives each bit's XOR from HI down, then the carry folds in.
    always_comb begin
        suffix    = up_data & MASK;
        nxt_data  = up_data;
        nxt_carry = up_carry;
        for (int sh = 1; sh < int'(WIDTH); sh = sh * 2) begin
            suffix = suffix ^ (suffix >> sh);
        end
        if (up_mode == MODE_B2G) begin
            if (FIRST) begin
                nxt_data = up_data ^ (up_data >> 1);
            end
        end else if (ACTIVE) begin
            nxt_data  = (up_data & ~MASK) | ((suffix ^ {WIDTH{up_carry}}) & MASK);
            nxt_carry = |(nxt_data & LO_BIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            mode  <= 1'b0;
            data  <= '0;
            carry <= 1'b0;
            err   <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                mode  <= up_mode;
                data  <= nxt_data;
                carry <= nxt_carry;
                err   <= up_err;
            end
        end
    end

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter with valid/ready on both sides.
// Define GRAY_STEP_CHECK_EN to flag Gray inputs whose Hamming step from the previous one is not 1.
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             step_err
);

    localparam int unsigned CHUNK = chunk_f(WIDTH, STAGES);

    // Index 0 is the input side; index s+1 is the output of stage s.
    logic [STAGES:0]  v;
    logic [STAGES:0]  m;
    logic [STAGES:0]  c;
    logic [STAGES:0]  e;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] d [STAGES+1];
    logic             carry_unused;

    assign v[0] = in_valid;
    assign m[0] = in_mode;
    assign d[0] = in_data;
    assign c[0] = 1'b0;

    // A stage can load when it, or any stage downstream of it, has room or the sink drains.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            rdy[k] = !v[k+1] || rdy[k+1];
        end
    end

    assign in_ready = !rst && rdy[0];

    for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
        localparam int HI_I   = int'(WIDTH) - 1 - s * int'(CHUNK);
        localparam int LO_RAW = int'(WIDTH) - (s + 1) * int'(CHUNK);
        localparam int LO_I   = (LO_RAW > 0) ? LO_RAW : 0;

        gray_codec_stage #(
            .WIDTH (WIDTH),
            .HI    (HI_I),
            .LO    (LO_I),
            .FIRST (s == 0)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (v[s]),
            .up_mode    (m[s]),
            .up_data    (d[s]),
            .up_carry   (c[s]),
            .up_err     (e[s]),
            .down_ready (rdy[s+1]),
            .valid      (v[s+1]),
            .mode       (m[s+1]),
            .data       (d[s+1]),
            .carry      (c[s+1]),
            .err        (e[s+1])
        );
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] last_word;
    logic             seen;
    logic             in_fire;

    assign in_fire = in_valid && in_ready;

    // History tracks only Gray-mode beats; binary beats pass untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_word <= '0;
            seen      <= 1'b0;
        end else if (in_fire && (in_mode == MODE_G2B)) begin
            last_word <= in_data;
            seen      <= 1'b1;
        end
    end

    assign e[0] = seen && (in_mode == MODE_G2B) &&
                  (popcount_xor(64'(in_data), 64'(last_word)) != 1);
`else
    assign e[0] = 1'b0;
`endif

    assign out_valid    = v[STAGES];
    assign out_mode     = m[STAGES];
    assign out_data     = d[STAGES];
    assign step_err     = e[STAGES];
    assign carry_unused = c[STAGES];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed and randomized checks of gray_codec_pipe at 4-bit/2-stage and 16-bit/3-stage.
module tb_gray_codec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 4-bit, 2-stage instance
    logic       a_rst, a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode, a_step_err;
    logic [3:0] a_in_data, a_out_data;

    gray_codec_pipe #(.WIDTH(4), .STAGES(2)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_mode(a_out_mode),
        .step_err(a_step_err)
    );

    // 16-bit, 3-stage instance
    logic        b_rst, b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode, b_step_err;
    logic [15:0] b_in_data, b_out_data;

    gray_codec_pipe #(.WIDTH(16), .STAGES(3)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode),
        .step_err(b_step_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] g2b16(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) b[i] = g[i] ^ b[i+1];
        return b;
    endfunction

    function automatic logic [15:0] b2g16(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    // Single beat, unstalled: result must appear exactly two cycles after accept.
    task automatic a_send_one(input string tag, input logic [3:0] din, input logic md, input logic [3:0] exp);
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_data   = din;
        a_in_mode   = md;
        a_out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(a_in_ready), 64'(1));
        @(negedge clk);
        a_in_valid = 1'b0;
        check({tag, "_early"}, 64'(a_out_valid), 64'(0));
        @(negedge clk);
        check({tag, "_valid"}, 64'(a_out_valid), 64'(1));
        check({tag, "_data"}, 64'(a_out_data), 64'(exp));
        check({tag, "_mode"}, 64'(a_out_mode), 64'(md));
    endtask

    // Entry: [32]=mode, [31:16]=input word, [15:0]=expected output
    logic [32:0] src[$];
    logic [32:0] sbq[$];
    logic [32:0] rt[$];

    task automatic b_run(input bit collect);
        logic [32:0] ent;
        int cyc;
        cyc = 0;
        while ((src.size() != 0 || sbq.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_valid  = (src.size() != 0) && ($urandom_range(0, 3) != 0);
            if (src.size() != 0) begin
                b_in_mode = src[0][32];
                b_in_data = src[0][31:16];
            end
            #1;
            if (b_out_valid && b_out_ready) begin
                if (sbq.size() == 0) begin
                    check("b_extra_beat", 64'(b_out_valid), 64'(0));
                end else begin
                    ent = sbq.pop_front();
                    check("b_data", 64'(b_out_data), 64'(ent[15:0]));
                    check("b_mode", 64'(b_out_mode), 64'(ent[32]));
                    if (collect && !ent[32] && rt.size() < 64)
                        rt.push_back({1'b1, b_out_data, ent[31:16]});
                end
            end
            if (b_in_valid && b_in_ready) sbq.push_back(src.pop_front());
            cyc++;
        end
        check("b_drained", 64'(src.size() + sbq.size()), 64'(0));
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    logic [3:0] alt_d[$] = '{4'b1101, 4'b1001, 4'b1000, 4'b0011};
    logic       alt_m[$] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] alt_e[$] = '{4'b1001, 4'b1101, 4'b1111, 4'b0010};

    logic [3:0] bp_d[$] = '{4'b0001, 4'b0011, 4'b0110, 4'b0101, 4'b1111};
    logic       bp_m[$] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] bp_e[$] = '{4'b0001, 4'b0010, 4'b0100, 4'b0111, 4'b1010};

    logic [3:0] st_d[$] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b0110};
    logic [3:0] st_e[$] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0100};
`ifdef GRAY_STEP_CHECK_EN
    logic       st_f[$] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic       st_f[$] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    initial begin
        logic [4:0] exq[$];
        logic [4:0] ent;
        logic [15:0] w;
        logic        md;
        int k;
        int got;

        a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_data", 64'(a_out_data), 64'(0));
        check("rst_out_mode", 64'(a_out_mode), 64'(0));
        check("rst_step_err", 64'(a_step_err), 64'(0));
        check("rst_in_ready_held", 64'(a_in_ready), 64'(0));
        a_rst = 1'b0;
        #1 check("rst_in_ready_after", 64'(a_in_ready), 64'(1));

        // Single beats
        a_send_one("g2b_1101", 4'b1101, 1'b0, 4'b1001);
        a_send_one("g2b_1000", 4'b1000, 1'b0, 4'b1111);
        a_send_one("g2b_0000", 4'b0000, 1'b0, 4'b0000);
        a_send_one("b2g_1001", 4'b1001, 1'b1, 4'b1101);

        // Alternating modes back-to-back
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("alt_valid", 64'(a_out_valid), 64'(1));
                check("alt_data", 64'(a_out_data), 64'(alt_e[i-2]));
                check("alt_mode", 64'(a_out_mode), 64'(alt_m[i-2]));
            end
            a_out_ready = 1'b1;
            a_in_valid  = (i < 4);
            if (i < 4) begin
                a_in_data = alt_d[i];
                a_in_mode = alt_m[i];
                #1 check("alt_in_ready", 64'(a_in_ready), 64'(1));
            end
        end

        // Backpressure: five beats, sink stalled for four cycles
        k = 0;
        got = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            @(negedge clk);
            a_out_ready = (c >= 4);
            a_in_valid  = (k < 5);
            if (k < 5) begin
                a_in_data = bp_d[k];
                a_in_mode = bp_m[k];
            end
            #1;
            if (c == 2 || c == 3) begin
                check("bp_in_ready_low", 64'(a_in_ready), 64'(0));
                check("bp_hold_valid", 64'(a_out_valid), 64'(1));
                check("bp_hold_data", 64'(a_out_data), 64'(4'b0001));
            end
            if (a_out_valid && a_out_ready) begin
                if (exq.size() == 0) begin
                    check("bp_extra_beat", 64'(a_out_valid), 64'(0));
                end else begin
                    ent = exq.pop_front();
                    check("bp_data", 64'(a_out_data), 64'(ent[3:0]));
                    check("bp_mode", 64'(a_out_mode), 64'(ent[4]));
                    got++;
                end
            end
            if (a_in_valid && a_in_ready) begin
                exq.push_back({bp_m[k], bp_e[k]});
                k++;
            end
        end
        check("bp_count", 64'(got), 64'(5));
        @(negedge clk);
        a_in_valid = 1'b0;
        check("bp_no_dup", 64'(a_out_valid), 64'(0));

        // Reset with two beats in flight
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 4'b0011; a_in_mode = 1'b0;
        @(negedge clk);
        a_in_data = 4'b0101; a_in_mode = 1'b1;
        @(negedge clk);
        a_rst = 1'b1;
        a_in_data = 4'b1111; a_in_mode = 1'b0;
        #1 check("mid_rst_no_accept", 64'(a_in_ready), 64'(0));
        @(negedge clk);
        a_rst = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        check("mid_rst_flush", 64'(a_out_valid), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_ghost", 64'(a_out_valid), 64'(0));
        end
        a_send_one("post_rst", 4'b0110, 1'b1, 4'b0101);

        // Gray step sequence
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("step_data", 64'(a_out_data), 64'(st_e[i-2]));
                check("step_err", 64'(a_step_err), 64'(st_f[i-2]));
            end
            a_out_ready = 1'b1;
            a_in_valid  = (i < 5);
            if (i < 5) begin
                a_in_data = st_d[i];
                a_in_mode = 1'b0;
            end
        end

        // Wide instance: random words, random stalls, then round trip
        @(negedge clk);
        b_rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            w  = 16'($urandom);
            md = 1'($urandom_range(0, 1));
            src.push_back({md, w, md ? b2g16(w) : g2b16(w)});
        end
        b_run(1'b1);
        while (rt.size() != 0) src.push_back(rt.pop_front());
        b_run(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
- Parametrised, pipelined Gray/binary converter with valid/ready handshakes on both sides.
- Each beat carries a mode bit selecting Gray→binary (prefix-XOR from MSB down) or binary→Gray (b ^ b>>1).
- The Gray→binary XOR chain is split across STAGES register stages so wide words close timing.
- Sits between Gray-coded position/pointer sources and binary datapath logic; also used in reverse to generate Gray pointers.

Parameters:
WIDTH, 4, data word width in bits (legal range 2..64).
STAGES, 2, pipeline register stages; fixed latency (legal range 1..WIDTH).

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
IN_VALID  input  1  input beat present.
IN_READY  output  1  block accepts beat this cycle.
IN_DATA  input  WIDTH  Gray or binary word.
IN_MODE  input  1  0 = Gray→binary, 1 = binary→Gray.
OUT_VALID  output  1  result beat present.
OUT_READY  input  1  downstream accepts beat.
OUT_DATA  output  WIDTH  converted word.
OUT_MODE  output  1  mode that travelled with the beat.
STEP_ERR  output  1  Gray step violation flag (see Optional Feature).

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset: on a CLK edge with RST=1, all stage valid bits clear. OUT_VALID=0, OUT_DATA=0, OUT_MODE=0, STEP_ERR=0. IN_READY=1 from the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded with no partial output. Beats offered while RST=1 are not accepted.
- Transfer rules:
  - Input transfer occurs when IN_VALID && IN_READY.
  - Output transfer occurs when OUT_VALID && OUT_READY.
  - OUT_DATA, OUT_MODE and STEP_ERR stay stable while OUT_VALID=1 and OUT_READY=0.
- Pipeline:
  - Stages 0..STAGES-1 each hold valid, mode, partial word and the resolved-bit carry.
  - Stage k loads from its upstream when stage k is empty or stage k+1 (or output) takes its beat this cycle. Bubbles collapse.
  - IN_READY = stage 0 empty or stage 0 advancing (combinational from OUT_READY through the chain).
  - Full throughput: one beat per cycle.
  - Latency: exactly STAGES cycles from input transfer to OUT_VALID when unstalled.
- Gray→binary:
  - CHUNK = ceil(WIDTH/STAGES).
  - Stage s resolves bits WIDTH-1-s*CHUNK down to max(0, WIDTH-(s+1)*CHUNK).
  - BIN[WIDTH-1]=G[WIDTH-1]; BIN[i]=G[i]^BIN[i+1].
  - The last resolved bit of each stage is the carry into the next stage.
  - Stages with no bits left pass data through.
- Binary→Gray: G = B ^ (B>>1), computed in stage 0; later stages pass through so latency is identical for both modes.
- Ordering: beats exit strictly in acceptance order regardless of mode mix.
- Simultaneous in/out transfer on a full pipe is allowed and sustains throughput.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- Defined:
  - The block keeps the last accepted MODE=0 input word plus a "seen" bit, both cleared by RST.
  - For each accepted MODE=0 beat with seen=1, a Hamming distance from the previous word other than exactly 1 sets that beat's STEP_ERR.
  - Distance 0 counts as an error.
  - MODE=1 beats never flag and never update the history.
  - The flag travels with the beat and appears with OUT_DATA.
- Undefined: STEP_ERR is tied to 0 and no history registers exist.

Decomposition:
- Package gray_pkg:
  - MODE_G2B=1'b0 and MODE_B2G=1'b1.
  - Function computing CHUNK from WIDTH and STAGES.
  - Helper function returning popcount of an XOR for the step check.
- Sub-module gray_codec_stage: one register stage holding valid, mode, data, carry and err, plus local handshake. Its bit-slice range is given by parameters.
- The top instantiates STAGES copies in a generate loop and adds the optional step checker.

Test Plan:
- WIDTH=4, STAGES=2, MODE=0, IN_DATA=4'b1101, OUT_READY=1 → OUT_DATA=4'b1001 exactly 2 cycles after accept. Also 4'b1000 → 4'b1111, and 4'b0000 → 4'b0000.
- MODE=1, IN_DATA=4'b1001 → OUT_DATA=4'b1101, OUT_MODE=1. Alternating modes back-to-back produce in-order results at 1 beat/cycle.
- Backpressure: 5 beats streamed, OUT_READY held 0 for 4 cycles. Required:
  - IN_READY drops after 2 beats are held in the pipe.
  - OUT_DATA stays stable while stalled.
  - No loss or duplication after release.
- Reset mid-stream: RST pulsed for 1 cycle with 2 beats in flight → OUT_VALID=0 next cycle, those beats never appear, and a new beat completes normally.
- WIDTH=16, STAGES=3, 1000 random words in both modes → matches reference model. Gray→binary→Gray round trip equals the original word.
- With GRAY_STEP_CHECK_EN, MODE=0 sequence 0000, 0001, 0011, 0110 → STEP_ERR = 0, 0, 0, 1. A repeat 0110 → 1.
